usb_tx_timer: RTL

//  Bit-timing and field sequencer for the USB transmit path; counterpart of the receive timer.

---
 rtl/usb_tx_timer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/usb_tx_timer.sv
// Bit-timing and field sequencer for the USB transmit path.
// Walks SYNC, PID, DATA, CRC16 and EOP, one bit_strobe per bit period, stretching a field on stuffed bits.
module usb_tx_timer #(
  parameter int CLKS_PER_BIT   = 8,
  parameter int MAX_DATA_BYTES = 64
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       tx_start,
  input  logic [6:0] num_bytes,
  input  logic       has_crc16,
  input  logic       stuff_insert,
  output logic       bit_strobe,
  output logic       load_byte,
  output logic       sync_active,
  output logic       pid_active,
  output logic       data_active,
  output logic       crc_active,
  output logic       eop_active,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = $clog2(MAX_DATA_BYTES * 8 + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_PID,
    S_DATA,
    S_CRC,
    S_EOP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [6:0]       nbytes_q, nbytes_d;
  logic             crc_q, crc_d;

  logic             busy;
  logic             strobe;
  logic             stuffed;
  logic             advance;
  logic             field_last;
  state_t           next_field;

  function automatic logic [6:0] clamp_bytes(input logic [6:0] n);
    logic [6:0] r;
    r = n;
    if (32'(n) > MAX_DATA_BYTES) r = 7'(MAX_DATA_BYTES);
    return r;
  endfunction

  function automatic logic [BIT_W-1:0] field_len(input state_t s, input logic [6:0] nb);
    logic [BIT_W-1:0] len;
    len = '0;
    case (s)
      S_SYNC, S_PID: len = BIT_W'(8);
      S_DATA:        len = BIT_W'({nb, 3'b000});
      S_CRC:         len = BIT_W'(16);
      S_EOP:         len = BIT_W'(3);
      default:       len = '0;
    endcase
    return len;
  endfunction

  // Empty DATA and absent CRC16 fields are skipped entirely.
  function automatic state_t following(input state_t s, input logic [6:0] nb, input logic crc);
    state_t n;
    n = S_IDLE;
    case (s)
      S_SYNC:  n = S_PID;
      S_PID:   n = (nb != 7'd0) ? S_DATA : (crc ? S_CRC : S_EOP);
      S_DATA:  n = crc ? S_CRC : S_EOP;
      S_CRC:   n = S_EOP;
      default: n = S_IDLE;
    endcase
    return n;
  endfunction

  assign busy       = (state_q != S_IDLE);
  assign strobe     = busy && (clk_cnt_q == CNT_LAST);
  assign stuffed    = strobe && stuff_insert && (state_q != S_EOP);
  assign advance    = strobe && !stuffed;
  assign field_last = (bit_cnt_q == field_len(state_q, nbytes_q) - BIT_W'(1));
  assign next_field = following(state_q, nbytes_q, crc_q);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= S_IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      nbytes_q  <= '0;
      crc_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      nbytes_q  <= nbytes_d;
      crc_q     <= crc_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    nbytes_d  = nbytes_q;
    crc_d     = crc_q;
    load_byte = 1'b0;
    tx_done   = 1'b0;

    if (state_q == S_IDLE) begin
      clk_cnt_d = '0;
      bit_cnt_d = '0;
      if (tx_start) begin
        nbytes_d = clamp_bytes(num_bytes);
        crc_d    = has_crc16;
        state_d  = S_SYNC;
      end
    end else begin
      clk_cnt_d = strobe ? '0 : clk_cnt_q + CNT_W'(1);
      if (advance) begin
        if (field_last) begin
          state_d   = next_field;
          bit_cnt_d = '0;
        end else begin
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
        end
      end
      // A byte boundary feeds the shift register unless the line is about to go to EOP.
      load_byte = advance && (state_q != S_EOP) && (bit_cnt_q[2:0] == 3'd7) &&
                  !(field_last && (next_field == S_EOP));
      tx_done   = advance && (state_q == S_EOP) && field_last;
    end
  end

  assign bit_strobe  = strobe;
  assign sync_active = (state_q == S_SYNC);
  assign pid_active  = (state_q == S_PID);
  assign data_active = (state_q == S_DATA);
  assign crc_active  = (state_q == S_CRC);
  assign eop_active  = (state_q == S_EOP);
  assign tx_busy     = busy;

endmodule
